// File: rtl/wb_timer_if.sv
// wishbone_if: pipelined Wishbone bus bundle shared by the core LSU master and the wb_timer slave.
// Latency: none, wires only.
// Backpressure: stall is driven by the slave; the SLAVE modport owns rdata/ack/stall.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        stall;

  modport SLAVE  (input cyc, stb, we, addr, sel, wdata, output rdata, ack, stall);
  modport MASTER (output cyc, stb, we, addr, sel, wdata, input rdata, ack, stall);
endinterface

// File: rtl/wb_timer.sv
// wb_timer: pipelined Wishbone slave exposing RISC-V mtime/mtimecmp, driving a level timer interrupt.
// Latency: ack and rdata 1 cycle after acceptance; irq_timer_o 1 cycle after the compare changes.
// Backpressure: never stalls, one request per cycle. Optional prescaler when WB_TIMER_PRESCALER_EN is defined.
module wb_timer #(
  parameter logic [63:0] MTIME_RST    = 64'h0,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  wishbone_if.SLAVE wb_if,
  output logic      irq_timer_o
);

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_PRESCALE    = 3'd4;

  // Byte-lane merge: selected bytes come from the bus, the rest keep their old value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_irq;

  logic        w_acc;
  logic        w_wr;
  logic [2:0]  w_reg;
  logic        w_tick;
  logic [31:0] w_prescale_ext;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_mtimecmp_nxt;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Acceptance is cyc&stb; a write with sel=0 is acked but touches nothing.
  assign w_acc = wb_if.cyc & wb_if.stb;
  assign w_wr  = w_acc & wb_if.we & (|wb_if.sel);
  assign w_reg = wb_if.addr[4:2];

  // Upper address bits are decoded by the interconnect; byte offset is ignored.
  assign w_unused = &{1'b0, wb_if.addr[31:5], wb_if.addr[1:0]};

`ifdef WB_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_wr_p;

  assign w_prescale_ext = 32'(r_prescale);
  assign w_wr_p         = w_wr & (w_reg == A_PRESCALE);
  assign w_tick         = (r_pcnt == r_prescale);

  // Prescale register and divider counter 0..P; writing P restarts the count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else if (w_wr_p) begin
      r_prescale <= PRESCALE_W'(f_merge(w_prescale_ext, wb_if.wdata, wb_if.sel));
      r_pcnt     <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRESCALE_W'(1);
    end
  end
`else
  logic w_unused_p;

  // No divider: mtime advances every cycle and register 4 reads as unmapped.
  assign w_prescale_ext = '0;
  assign w_tick         = 1'b1;
  assign w_unused_p     = (PRESCALE_W == 0);
`endif

  // Next-state for mtime/mtimecmp: a write to either mtime half replaces the selected
  // bytes and holds the whole counter for that cycle, so no carry crosses the halves.
  always_comb begin
    w_mtime_nxt    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr) begin
      case (w_reg)
        A_MTIME_LO:    w_mtime_nxt    = {r_mtime[63:32], f_merge(r_mtime[31:0], wb_if.wdata, wb_if.sel)};
        A_MTIME_HI:    w_mtime_nxt    = {f_merge(r_mtime[63:32], wb_if.wdata, wb_if.sel), r_mtime[31:0]};
        A_MTIMECMP_LO: w_mtimecmp_nxt = {r_mtimecmp[63:32], f_merge(r_mtimecmp[31:0], wb_if.wdata, wb_if.sel)};
        A_MTIMECMP_HI: w_mtimecmp_nxt = {f_merge(r_mtimecmp[63:32], wb_if.wdata, wb_if.sel), r_mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  // Read mux over the registered values, i.e. read-before-write within a cycle.
  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      A_MTIME_LO:    w_rd_val = r_mtime[31:0];
      A_MTIME_HI:    w_rd_val = r_mtime[63:32];
      A_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
      A_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
      A_PRESCALE:    w_rd_val = w_prescale_ext;
      default: ;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mtime    <= MTIME_RST;
      r_mtimecmp <= MTIMECMP_RST;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
    end
  end

  // Bus response: ack one cycle after acceptance, rdata zero for writes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !wb_if.we) ? w_rd_val : '0;
    end
  end

  // Level interrupt from the current register values; no sticky state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  // A master that drops cyc after issuing a request abandons it, so its ack is withheld.
  assign wb_if.ack   = r_ack & wb_if.cyc;
  assign wb_if.rdata = r_rdata;
  assign wb_if.stall = 1'b0;
  assign irq_timer_o = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed bus sequences against wb_timer with a queue-based response scoreboard.
// Stimulus pushes the hand-computed rdata of every acked request; a negedge monitor pops on ack.
// Timing: n_edges counts posedges since reset release; request issued after edge k is accepted at k+1.
module tb_wb_timer;
  logic clk_i = 1'b0;
  logic rstn_i;
  logic irq;

  wishbone_if wb();

  wb_timer dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wb_if      (wb),
    .irq_timer_o(irq)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] MLO = 32'h00;
  localparam logic [31:0] MHI = 32'h04;
  localparam logic [31:0] CLO = 32'h08;
  localparam logic [31:0] CHI = 32'h0C;
  localparam logic [31:0] PRE = 32'h10;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned n_edges = 0;
  int          ack_run = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) if (rstn_i) n_edges <= n_edges + 1;

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (wb.ack === 1'b1) begin
      ack_run++;
      chk("stall_during_ack", {63'd0, wb.stall}, 64'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with nothing outstanding, rdata 0x%0h", wb.rdata);
      end else begin
        chk(name_q.pop_front(), {32'd0, wb.rdata}, {32'd0, exp_q.pop_front()});
      end
    end else begin
      ack_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go(input int unsigned k);
    wb.stb = 1'b0;
    if (n_edges > k) begin
      n_tests++;
      n_fail++;
      $display("FAIL schedule: already at edge %0d, wanted %0d", n_edges, k);
    end
    while (n_edges < k) tick();
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] wd, input string name, input logic [31:0] exp);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
    wb.addr = addr; wb.sel = sel; wb.wdata = wd;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    wb.stb = 1'b0;
    wb.we  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd, input string name);
    bus(1'b1, addr, sel, wd, name, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
    bus(1'b0, addr, 4'hF, 32'h0, name, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.addr = '0; wb.sel = '0; wb.wdata = '0;
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;
    #11;
    chk("reset_ack",   {63'd0, wb.ack},   64'd0);
    chk("reset_rdata", {32'd0, wb.rdata}, 64'd0);
    chk("reset_stall", {63'd0, wb.stall}, 64'd0);
    chk("reset_irq",   {63'd0, irq},      64'd0);
    #10 rstn_i = 1'b1;
    wb.cyc = 1'b1;
    tick();                                   // edge 1

    // Idle count, reset compare values, then arm the compare at 20.
    go(10);
    chk("irq_idle", {63'd0, irq}, 64'd0);
    rd(MLO, "mtime_lo_after_idle", 32'd10);   // accepted at edge 11
    rd(CLO, "mtimecmp_lo_reset", 32'hFFFF_FFFF);
    rd(CHI, "mtimecmp_hi_reset", 32'hFFFF_FFFF);
    wr(CHI, 4'hF, 32'd0,  "wr_mtimecmp_hi");
    wr(CLO, 4'hF, 32'd20, "wr_mtimecmp_lo");  // cmp=20 after edge 15
    go(20);
    chk("irq_before_match", {63'd0, irq}, 64'd0);
    go(21);
    chk("irq_after_match",  {63'd0, irq}, 64'd1);
    wr(CLO, 4'hF, 32'hFFFF_FFFF, "wr_mtimecmp_lo_high"); // lands at edge 22
    chk("irq_one_cycle_after_write", {63'd0, irq}, 64'd1);
    go(23);
    chk("irq_falls", {63'd0, irq}, 64'd0);

    // Carry across halves plus a back-to-back burst.
    wr(MHI, 4'hF, 32'd0,          "wr_mtime_hi");   // edge 24
    wr(MLO, 4'hF, 32'hFFFF_FFFE,  "wr_mtime_lo");   // edge 25: mtime = 0:FFFFFFFE
    rd(MHI, "mtime_hi_pre_carry",  32'd0);          // edge 26
    rd(MLO, "mtime_lo_all_ones",   32'hFFFF_FFFF);  // edge 27
    rd(MHI, "mtime_hi_carry",      32'd1);          // edge 28
    rd(MLO, "mtime_lo_wrapped",    32'd1);          // edge 29
    tick();
    chk("ack_run_back_to_back", ack_run, 64'd6);
    chk("irq_64bit_compare", {63'd0, irq}, 64'd1); // mtime 1:xx >= 0:FFFFFFFF

    // Byte lanes, sel=0, unmapped space, ignored byte offset.
    wr(CLO, 4'b0010, 32'h0000_AB00, "wr_cmp_lo_byte1");
    rd(CLO, "mtimecmp_lo_byte1", 32'hFFFF_ABFF);
    wr(CHI, 4'b0000, 32'h1234_5678, "wr_cmp_hi_sel0");
    rd(CHI, "mtimecmp_hi_sel0",  32'd0);
    wr(32'h14, 4'hF, 32'hDEAD_BEEF, "wr_unmapped5");
    rd(32'h14, "rd_unmapped5", 32'd0);
    rd(32'h1C, "rd_unmapped7", 32'd0);
    rd(32'h0B, "rd_offset_ignored", 32'hFFFF_ABFF);

    // Write abandoned by dropping cyc: no ack, but it still commits.
    wb.stb = 1'b1; wb.we = 1'b1; wb.addr = CHI; wb.sel = 4'hF; wb.wdata = 32'd5;
    tick();
    wb.stb = 1'b0; wb.we = 1'b0; wb.cyc = 1'b0;
    tick();
    wb.cyc = 1'b1;
    chk("irq_after_cmp_hi_raise", {63'd0, irq}, 64'd0);
    rd(CHI, "suppressed_write_committed", 32'd5);   // accepted at edge 41

`ifdef WB_TIMER_PRESCALER_EN
    wr(PRE, 4'hF, 32'd3,   "wr_prescale");          // edge 42: P=3, c=0
    wr(MLO, 4'hF, 32'd100, "wr_mtime_lo_100");      // edge 43
    rd(PRE, "prescale_readback", 32'd3);            // edge 44
    go(47);
    rd(MLO, "prescaled_first_tick", 32'd101);       // tick at edge 46
    go(49);
    rd(MLO, "prescaled_hold", 32'd101);             // edge 50 reads pre-tick value
    rd(MLO, "prescaled_second_tick", 32'd102);      // edge 51
`else
    wr(PRE, 4'hF, 32'd3,   "wr_reg4_unmapped");     // edge 42
    rd(PRE, "reg4_reads_zero", 32'd0);              // edge 43
    wr(MLO, 4'hF, 32'd100, "wr_mtime_lo_100");      // edge 44
    rd(MLO, "mtime_lo_100", 32'd100);               // edge 45
    rd(MLO, "mtime_lo_101", 32'd101);               // edge 46
`endif

    // Reset lands while a read is waiting for its ack.
    wb.stb = 1'b1; wb.we = 1'b0; wb.addr = MLO; wb.sel = 4'hF;
    tick();
    wb.stb = 1'b0;
    rstn_i = 1'b0;
    #2;
    chk("midreset_ack",   {63'd0, wb.ack},   64'd0);
    chk("midreset_rdata", {32'd0, wb.rdata}, 64'd0);
    chk("midreset_irq",   {63'd0, irq},      64'd0);
    #4 rstn_i = 1'b1;
    tick();                                         // first edge after release: mtime=1
    rd(MLO, "mtime_lo_after_reset",    32'd1);
    rd(CHI, "mtimecmp_hi_after_reset", 32'hFFFF_FFFF);
    rd(CLO, "mtimecmp_lo_after_reset", 32'hFFFF_FFFF);
    tick();
    tick();
    chk("outstanding_acks", exp_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
